// File: rtl/riscv_boot_loader_if.sv
// Byte-stream receive and instruction-memory write bundle for riscv_boot_loader.
// The slave modport is the loader; the master modport is the byte source / memory observer.
interface riscv_boot_loader_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          rx_valid_i;
    logic [7:0]    rx_data_i;
    logic          rx_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [DW-1:0] imem_wdata_o;
    logic          core_rst_o;
    logic          done_o;
    logic          err_o;

    modport slave (
        input  rx_valid_i, rx_data_i,
        output rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_rst_o, done_o, err_o
    );

    modport master (
        output rx_valid_i, rx_data_i,
        input  rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_rst_o, done_o, err_o
    );
endinterface

// File: rtl/riscv_boot_loader.sv
// Receives a framed program image byte by byte, writes it word by word into the
// core's instruction memory, and releases the core from reset once the checksum matches.
module riscv_boot_loader #(
    parameter int         DW             = 32,
    parameter int         MEM_SIZE_IN_KB = 1,
    parameter int         NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int         AW             = $clog2(NO_OF_REGS),
    parameter logic [7:0] MAGIC          = 8'hA5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    riscv_boot_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_e;

    localparam logic [16:0] MAX_LEN = 17'(NO_OF_REGS);

    state_e        state_q, state_d;
    logic [15:0]   len_q,   len_d;
    logic [15:0]   idx_q,   idx_d;
    logic [7:0]    csum_q,  csum_d;
    logic [1:0]    cnt_q,   cnt_d;
    logic [DW-1:0] word_q,  word_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          we_q,    we_d;

    logic          accept;
    logic [7:0]    rx_byte;
    logic [15:0]   len_full;

    assign rx_byte  = bus.rx_data_i;
    assign accept   = bus.rx_valid_i && (state_q != RUN);
    assign len_full = {rx_byte, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        we_d    = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE, ERROR: begin
                    if (rx_byte == MAGIC) begin
                        state_d = LEN0;
                        csum_d  = '0;
                    end
                end
                LEN0: begin
                    len_d   = {8'h00, rx_byte};
                    csum_d  = csum_q ^ rx_byte;
                    state_d = LEN1;
                end
                LEN1: begin
                    len_d  = len_full;
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = '0;
                    cnt_d  = '0;
                    // Oversized images are rejected here so no memory location is touched.
                    if (len_full == '0)
                        state_d = CSUM;
                    else if ({1'b0, len_full} > MAX_LEN)
                        state_d = ERROR;
                    else
                        state_d = DATA;
                end
                DATA: begin
                    csum_d                        = csum_q ^ rx_byte;
                    word_d[{cnt_q, 3'b000} +: 8] = rx_byte;
                    cnt_d                         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[AW-1:0];
                        wdata_d = word_d;
                        idx_d   = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1)
                            state_d = CSUM;
                    end
                end
                CSUM: begin
                    state_d = (rx_byte == csum_q) ? RUN : ERROR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    // Status outputs decode the state register only, so rx never reaches them combinationally.
    assign bus.rx_ready_o   = (state_q != RUN);
    assign bus.core_rst_o   = (state_q != RUN);
    assign bus.done_o       = (state_q == RUN);
    assign bus.err_o        = (state_q == ERROR);
    assign bus.imem_we_o    = we_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Bench for riscv_boot_loader: table-driven frames, hand-timed sequences and random frames
// checked against a frame-parsing reference model.
module tb_riscv_boot_loader;

    localparam int         DW    = 32;
    localparam int         AW    = 8;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_boot_loader_if #(.DW(DW), .AW(AW)) bus ();

    riscv_boot_loader #(
        .DW             (DW),
        .MEM_SIZE_IN_KB (1),
        .MAGIC          (MAGIC)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct packed {
        logic [255:0] bytes;
        logic [7:0]   n;
        logic         exp_done;
        logic         exp_err;
        logic [7:0]   exp_writes;
    } vec_t;

    int unsigned       checks = 0;
    int unsigned       errors = 0;
    logic [7:0]        frame_q [$];
    logic [AW+DW-1:0]  got_w   [$];
    logic [AW+DW-1:0]  exp_w   [$];
    logic              m_done;
    logic              m_err;
    vec_t              tbl [7];

    always @(negedge clk_i)
        if (rst_ni && bus.imem_we_o)
            got_w.push_back({bus.imem_addr_o, bus.imem_wdata_o});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the byte list as a sequence of frames.
    function automatic void model();
        int unsigned p, n, len;
        logic [7:0]    cs;
        logic [DW-1:0] word;
        exp_w.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        p = 0;
        n = frame_q.size();
        while (p < n && !m_done) begin
            if (frame_q[p] != MAGIC) begin
                p++;
                continue;
            end
            if (p + 2 >= n) break;
            m_err = 1'b0;
            len = {16'h0, frame_q[p+2], frame_q[p+1]};
            cs  = frame_q[p+1] ^ frame_q[p+2];
            p  += 3;
            if (len > 256) begin
                m_err = 1'b1;
                continue;
            end
            for (int unsigned w = 0; w < len; w++) begin
                word = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]};
                cs   = cs ^ frame_q[p] ^ frame_q[p+1] ^ frame_q[p+2] ^ frame_q[p+3];
                exp_w.push_back({AW'(w), word});
                p += 4;
            end
            if (p >= n) break;
            if (frame_q[p] == cs) m_done = 1'b1;
            else                  m_err  = 1'b1;
            p++;
        end
    endfunction

    task automatic do_reset();
        rst_ni         = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (2) @(negedge clk_i);
        got_w.delete();
        rst_ni = 1'b1;
    endtask

    task automatic send_frame(input int unsigned gap_pct);
        int unsigned t;
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk_i);
            while ($urandom_range(99) < gap_pct) begin
                bus.rx_valid_i = 1'b0;
                @(negedge clk_i);
            end
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = frame_q[i];
            t = 0;
            while (!bus.rx_ready_o && t < 50) begin
                @(negedge clk_i);
                t++;
            end
            if (t >= 50) begin
                chk("rx_ready_timeout", 64'd0, 64'd1);
                bus.rx_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic exp_done, input logic exp_err);
        repeat (2) @(negedge clk_i);
        chk({tag, "_done"},     64'(bus.done_o),     64'(exp_done));
        chk({tag, "_err"},      64'(bus.err_o),      64'(exp_err));
        chk({tag, "_core_rst"}, 64'(bus.core_rst_o), 64'(!exp_done));
        chk({tag, "_rx_ready"}, 64'(bus.rx_ready_o), 64'(!exp_done));
        chk({tag, "_nwrites"},  64'(got_w.size()),   64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    task automatic step_byte(input logic [7:0] b);
        @(negedge clk_i);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_vec(input int v);
        frame_q.delete();
        for (int i = 0; i < int'(tbl[v].n); i++)
            frame_q.push_back(tbl[v].bytes[8*(int'(tbl[v].n)-1-i) +: 8]);
    endtask

    initial begin
        tbl[0] = '{bytes: 256'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                8'h93, 8'h00, 8'hA0, 8'h00, 8'h72}),
                   n: 8'd12, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd2};
        tbl[1] = '{bytes: 256'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                8'h93, 8'h00, 8'hA0, 8'h00, 8'h71}),
                   n: 8'd12, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 8'd2};
        tbl[2] = '{bytes: 256'({8'hA5, 8'h01, 8'h01}),
                   n: 8'd3, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 8'd0};
        tbl[3] = '{bytes: 256'({8'h11, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}),
                   n: 8'd6, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd0};
        tbl[4] = '{bytes: 256'({8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01}),
                   n: 8'd8, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd1};
        tbl[5] = '{bytes: 256'({8'hA5, 8'h01, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h00}),
                   n: 8'd7, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd0};
        tbl[6] = '{bytes: 256'({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                8'h93, 8'h00, 8'hA0, 8'h00, 8'h71,
                                8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                8'h93, 8'h00, 8'hA0, 8'h00, 8'h72}),
                   n: 8'd24, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 8'd4};

        // Reset values
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (2) @(negedge clk_i);
        chk("rst_rx_ready", 64'(bus.rx_ready_o), 64'd1);
        chk("rst_core_rst", 64'(bus.core_rst_o), 64'd1);
        chk("rst_we",       64'(bus.imem_we_o),  64'd0);
        chk("rst_done",     64'(bus.done_o),     64'd0);
        chk("rst_err",      64'(bus.err_o),      64'd0);
        chk("rst_addr",     64'(bus.imem_addr_o), 64'd0);
        chk("rst_wdata",    64'(bus.imem_wdata_o), 64'd0);

        // Exact write-pulse and release timing
        do_reset();
        step_byte(8'hA5); step_byte(8'h02); step_byte(8'h00);
        step_byte(8'h13); step_byte(8'h00); step_byte(8'h50);
        step_byte(8'h00);
        chk("t_w0_we",    64'(bus.imem_we_o),    64'd1);
        chk("t_w0_addr",  64'(bus.imem_addr_o),  64'd0);
        chk("t_w0_data",  64'(bus.imem_wdata_o), 64'h00500013);
        step_byte(8'h93);
        chk("t_w0_pulse", 64'(bus.imem_we_o),    64'd0);
        chk("t_w0_hold",  64'(bus.imem_wdata_o), 64'h00500013);
        step_byte(8'h00); step_byte(8'hA0); step_byte(8'h00);
        chk("t_w1_we",    64'(bus.imem_we_o),    64'd1);
        chk("t_w1_addr",  64'(bus.imem_addr_o),  64'd1);
        chk("t_w1_data",  64'(bus.imem_wdata_o), 64'h00A00093);
        chk("t_pre_done", 64'(bus.done_o),       64'd0);
        step_byte(8'h72);
        chk("t_done",     64'(bus.done_o),       64'd1);
        chk("t_core_rst", 64'(bus.core_rst_o),   64'd0);
        chk("t_rx_ready", 64'(bus.rx_ready_o),   64'd0);
        @(negedge clk_i);
        bus.rx_valid_i = 1'b0;

        // Abort mid-frame after two data bytes
        do_reset();
        step_byte(8'hA5); step_byte(8'h02); step_byte(8'h00);
        step_byte(8'h13); step_byte(8'h00);
        @(negedge clk_i);
        bus.rx_valid_i = 1'b0;
        rst_ni         = 1'b0;
        #1;
        chk("abort_rx_ready", 64'(bus.rx_ready_o), 64'd1);
        chk("abort_core_rst", 64'(bus.core_rst_o), 64'd1);
        chk("abort_we",       64'(bus.imem_we_o),  64'd0);
        chk("abort_done",     64'(bus.done_o),     64'd0);
        chk("abort_err",      64'(bus.err_o),      64'd0);
        chk("abort_nwrites",  64'(got_w.size()),   64'd0);
        do_reset();
        load_vec(0);
        model();
        send_frame(30);
        check_result("abort_reload", 1'b1, 1'b0);

        // Table vectors, back-to-back and with random gaps
        for (int v = 0; v < 7; v++) begin
            for (int g = 0; g < 2; g++) begin
                do_reset();
                load_vec(v);
                model();
                send_frame(g == 0 ? 0 : 50);
                check_result($sformatf("v%0d_g%0d", v, g), tbl[v].exp_done, tbl[v].exp_err);
                chk($sformatf("v%0d_g%0d_tblwrites", v, g), 64'(got_w.size()), 64'(tbl[v].exp_writes));
            end
        end

        // Random frames, including full-memory and one-over-limit lengths
        for (int it = 0; it < 20; it++) begin
            int unsigned len;
            logic [7:0]  cs;
            logic [7:0]  b;
            do_reset();
            frame_q.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom_range(0, 255));
                frame_q.push_back(b == MAGIC ? 8'h00 : b);
            end
            len = (it == 0) ? 256 : (it == 1) ? 257 : $urandom_range(0, 6);
            frame_q.push_back(MAGIC);
            frame_q.push_back(len[7:0]);
            frame_q.push_back(len[15:8]);
            cs = len[7:0] ^ len[15:8];
            if (len <= 256) begin
                for (int unsigned j = 0; j < 4 * len; j++) begin
                    b  = 8'($urandom_range(0, 255));
                    cs = cs ^ b;
                    frame_q.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
                frame_q.push_back(cs);
            end
            model();
            send_frame(it % 2 == 0 ? 0 : 40);
            check_result($sformatf("rand%0d", it), m_done, m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
